// File: rtl/phase_sweep_ctrl.sv
// MMCM phase sweep: steps the clock phase, averages TDC thermometer popcounts per step,
// keeps the step closest to mid-scale, then steps back to it.
module phase_sweep_ctrl #(
   parameter int unsigned STEPS         = 64,
   parameter int unsigned SAMPLES       = 16,
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned TIMEOUT       = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        locked,
   output logic        ps_en,
   output logic        ps_incdec,
   input  logic        ps_done,
   output logic        cap_req,
   input  logic [63:0] tdc_data,
   input  logic        data_valid,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  best_step,
   output logic [14:0] best_score
);

   localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
   localparam int unsigned CntW   = $clog2(CntMax + 1) + 1;

   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutC   = CntW'(TIMEOUT);
   localparam logic [7:0]      LastStep   = 8'(STEPS - 1);
   localparam logic [8:0]      NumSamples = 9'(SAMPLES);
   localparam logic [14:0]     Target     = 15'(32 * SAMPLES);

   typedef enum logic [3:0] {
      StIdle,
      StSettle,
      StCapture,
      StWaitv,
      StEval,
      StShift,
      StReturn,
      StDone,
      StErr
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [7:0]      step_q;
   logic [14:0]     acc_q;
   logic [8:0]      samp_q;
   logic [7:0]      ret_q;
   logic            shift_out_q;

   logic [6:0]  pop;
   logic [14:0] score;
   logic        better;
   logic [7:0]  best_step_nxt;
   logic [8:0]  samp_inc;
   logic        lock_lost;

   function automatic logic [6:0] popcount(input logic [63:0] w);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + 7'(w[i]);
      end
      return n;
   endfunction

   always_comb begin
      pop           = popcount(tdc_data);
      score         = (acc_q >= Target) ? (acc_q - Target) : (Target - acc_q);
      better        = (score < best_score);
      best_step_nxt = better ? step_q : best_step;
      samp_inc      = samp_q + 9'd1;
      lock_lost     = !locked && (state_q != StIdle) && (state_q != StDone)
                      && (state_q != StErr);
   end

   assign busy = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         step_q      <= '0;
         acc_q       <= '0;
         samp_q      <= '0;
         ret_q       <= '0;
         shift_out_q <= 1'b0;
         ps_en       <= 1'b0;
         ps_incdec   <= 1'b0;
         cap_req     <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         best_step   <= '0;
         best_score  <= 15'h7FFF;
      end else begin
         ps_en     <= 1'b0;
         ps_incdec <= 1'b0;
         cap_req   <= 1'b0;
         done      <= 1'b0;
         if (busy && abort) begin
            // Any outstanding shift is simply abandoned.
            state_q <= StIdle;
         end else if (lock_lost) begin
            state_q <= StErr;
            err     <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start && locked && !abort) begin
                     state_q     <= StSettle;
                     cnt_q       <= '0;
                     step_q      <= '0;
                     acc_q       <= '0;
                     samp_q      <= '0;
                     shift_out_q <= 1'b0;
                     err         <= 1'b0;
                     best_step   <= '0;
                     best_score  <= 15'h7FFF;
                  end
               end
               StSettle: begin
                  if (cnt_q >= SettleLast) begin
                     cnt_q   <= '0;
                     state_q <= StCapture;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StCapture: begin
                  cap_req <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StWaitv;
               end
               StWaitv: begin
                  if (data_valid) begin
                     acc_q   <= acc_q + 15'(pop);
                     samp_q  <= samp_inc;
                     cnt_q   <= '0;
                     state_q <= (samp_inc < NumSamples) ? StCapture : StEval;
                  end else if (cnt_q == TimeoutC) begin
                     state_q <= StErr;
                     err     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StEval: begin
                  // Strict compare: the earliest step wins a tie.
                  if (better) begin
                     best_score <= score;
                     best_step  <= step_q;
                  end
                  acc_q       <= '0;
                  samp_q      <= '0;
                  cnt_q       <= '0;
                  shift_out_q <= 1'b0;
                  if (step_q == LastStep) begin
                     ret_q   <= LastStep - best_step_nxt;
                     state_q <= StReturn;
                  end else begin
                     state_q <= StShift;
                  end
               end
               StShift: begin
                  if (!shift_out_q) begin
                     ps_en       <= 1'b1;
                     ps_incdec   <= 1'b1;
                     shift_out_q <= 1'b1;
                     cnt_q       <= '0;
                  end else if (ps_done) begin
                     shift_out_q <= 1'b0;
                     step_q      <= step_q + 8'd1;
                     cnt_q       <= '0;
                     state_q     <= StSettle;
                  end else if (cnt_q == TimeoutC) begin
                     state_q <= StErr;
                     err     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StReturn: begin
                  if (!shift_out_q) begin
                     if (ret_q == 8'd0) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        ps_en       <= 1'b1;
                        shift_out_q <= 1'b1;
                        ret_q       <= ret_q - 8'd1;
                        cnt_q       <= '0;
                     end
                  end else if (ps_done) begin
                     shift_out_q <= 1'b0;
                  end else if (cnt_q == TimeoutC) begin
                     state_q <= StErr;
                     err     <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
               StDone: state_q <= StIdle;
               StErr:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: doc/phase_sweep_ctrl.md
PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 SHALL have parameter STEPS, default 64, meaning the number of phase positions swept (2..256).
REQ-002 SHALL have parameter SAMPLES, default 16, meaning the TDC captures averaged per step (power of two, 1..256).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 64, meaning idle cycles after each phase change before capture.
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning maximum cycles waited for ps_done or data_valid.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning the synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle request to begin a sweep.
REQ-008 SHALL have port abort, input, 1, meaning a level request to terminate the sweep.
REQ-009 SHALL have port locked, input, 1, meaning the MMCM is locked.
REQ-010 SHALL have port ps_en, output, 1, meaning the MMCM phase-shift strobe.
REQ-011 SHALL have port ps_incdec, output, 1, meaning the phase-shift direction (1 = increment).
REQ-012 SHALL have port ps_done, input, 1, meaning the MMCM has completed a phase shift.
REQ-013 SHALL have port cap_req, output, 1, meaning a one-cycle pulse that triggers one TDC capture.
REQ-014 SHALL have port tdc_data, input, 64, meaning the delay-line thermometer word.
REQ-015 SHALL have port data_valid, input, 1, meaning tdc_data is valid this cycle.
REQ-016 SHALL have port busy, output, 1, meaning a sweep is in progress.
REQ-017 SHALL have port done, output, 1, meaning a one-cycle pulse when a sweep completes successfully.
REQ-018 SHALL have port err, output, 1, meaning a sticky failure flag.
REQ-019 SHALL have port best_step, output, 8, meaning the phase step index with the best score.
REQ-020 SHALL have port best_score, output, 15, meaning the minimum score found.

Function
REQ-021 SHALL implement the states IDLE, SETTLE, CAPTURE, WAITV, EVAL, SHIFT, RETURN, DONE and ERR.
REQ-022 IDLE SHALL go to SETTLE on start && locked, clearing step_idx, the accumulator and the sample count, and setting best_score to all-ones; start while not locked, or start while not in IDLE, SHALL be ignored.
REQ-023 SETTLE SHALL wait exactly SETTLE_CYCLES cycles and then go to CAPTURE.
REQ-024 CAPTURE SHALL assert cap_req for one cycle and go to WAITV.
REQ-025 WAITV, on data_valid, SHALL add popcount(tdc_data) (0..64) to the accumulator and increment the sample count.
REQ-026 From WAITV, the block SHALL return to CAPTURE if the sample count is below SAMPLES, and otherwise go to EVAL.
REQ-027 data_valid outside WAITV SHALL be ignored.
REQ-028 EVAL SHALL compute score = |acc − 32·SAMPLES|, using 15-bit unsigned arithmetic with no overflow.
REQ-029 In EVAL, if score < best_score (strictly less, so the earlier step wins a tie), best_score and best_step SHALL update.
REQ-030 EVAL SHALL clear the accumulator and sample count, then go to RETURN if step_idx == STEPS−1, and otherwise go to SHIFT.
REQ-031 SHIFT SHALL pulse ps_en for one cycle with ps_incdec=1, wait for ps_done, increment step_idx, and go to SETTLE.
REQ-032 RETURN SHALL issue (STEPS−1−best_step) decrement shifts with ps_incdec=0, each being one ps_en pulse followed by waiting for ps_done, and then go to DONE.
REQ-033 When best_step equals STEPS−1, RETURN SHALL issue zero shifts.
REQ-034 ps_en SHALL never be asserted while a previous shift is outstanding, i.e. before its ps_done.
REQ-035 DONE SHALL pulse done for one cycle and go to IDLE.
REQ-036 best_step and best_score SHALL hold their values until the next start.
REQ-037 Any wait in WAITV, SHIFT or RETURN that exceeds TIMEOUT cycles SHALL go to ERR.
REQ-038 Deassertion of locked while busy SHALL go to ERR.
REQ-039 ERR SHALL set err, which is sticky until the next accepted start or rst, and SHALL then go to IDLE.
REQ-040 abort while busy SHALL go to IDLE on the next cycle without a done pulse and without issuing new ps_en; a shift already outstanding is abandoned.
REQ-041 abort and start asserted in the same cycle in IDLE SHALL be treated as abort, and the start is ignored.
REQ-042 busy SHALL be 1 in every state except IDLE.

Reset
REQ-043 When rst is asserted, the block SHALL go to IDLE within one clock.
REQ-044 Under reset, ps_en, ps_incdec, cap_req, busy, done and err SHALL be 0, best_step SHALL be 0, best_score SHALL be 0x7FFF, and all counters SHALL be 0.
REQ-045 Reset asserted mid-sweep SHALL behave identically to reset from IDLE.

Verification
REQ-046 Nominal sweep: STEPS=4, SAMPLES=2, and the model returns popcounts 10, 30, 33, 50 per step -> best_step=2, best_score=2 (|66−64|), one RETURN decrement is observed, and done pulses once.
REQ-047 Tie case: scores equal at steps 1 and 3 -> best_step=1, and two decrements are issued.
REQ-048 ps_done is withheld in SHIFT for TIMEOUT+1 cycles -> err=1, busy=0, and no further ps_en is issued.
REQ-049 locked drops during SETTLE -> ERR, after which IDLE follows with err=1; a start while locked=0 is then ignored.
REQ-050 abort asserted during WAITV at step 2 -> busy=0 next cycle, no done pulse, best_step keeps its last EVAL value.
REQ-051 rst asserted during RETURN -> all outputs take their REQ-044 values on the next cycle, and ps_en stays 0.
